// File: rtl/constants_pkg.sv
// Shared constants and types for the decode/execute boundary.
package constants_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0 -- canonical bubble instruction
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Payload carried from decode into execute (default widths).
  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             insn;
    logic [DATA_WIDTH-1:0]   imm;
    logic [REG_ADDR_W-1:0]   rs1;
    logic [REG_ADDR_W-1:0]   rs2;
    logic [REG_ADDR_W-1:0]   rd;
    logic [DATA_WIDTH-1:0]   rs1data;
    logic [DATA_WIDTH-1:0]   rs2data;
    logic                    regwren;
    logic                    memren;
  } id_ex_payload_t;

endpackage

// File: rtl/operand_bypass.sv
// Operand select: x0 reads zero, a same-cycle writeback to the addressed
// register overrides the register-file read data.
module operand_bypass
  import constants_pkg::*;
#(
  parameter int DWIDTH = DATA_WIDTH
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [DWIDTH-1:0]     rf_data_i,
  input  logic                  wb_regwren_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [DWIDTH-1:0]     wb_data_i,
  output logic [DWIDTH-1:0]     data_o
);

  // Zero register dominates, then writeback forwarding, then RF data
  always_comb begin
    data_o = rf_data_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (wb_regwren_i && (wb_rd_i == rs_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode -> execute pipeline register with load-use stall, bubble
// insertion, flush and writeback forwarding into captured/held operands.
module id_ex_stage
  import constants_pkg::*;
#(
  parameter int DWIDTH = DATA_WIDTH,
  parameter int AWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [AWIDTH-1:0]     pc_i,
  input  logic [31:0]           insn_i,
  input  logic [DWIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  uses_rs1_i,
  input  logic                  uses_rs2_i,
  input  logic                  regwren_i,
  input  logic                  memren_i,
  input  logic [DWIDTH-1:0]     rs1data_i,
  input  logic [DWIDTH-1:0]     rs2data_i,
  input  logic                  wb_regwren_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [DWIDTH-1:0]     wb_data_i,
  input  logic                  flush_i,
  input  logic                  ex_ready_i,
  output logic                  ex_valid_o,
  output logic [AWIDTH-1:0]     pc_o,
  output logic [31:0]           insn_o,
  output logic [DWIDTH-1:0]     imm_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [DWIDTH-1:0]     rs1data_o,
  output logic [DWIDTH-1:0]     rs2data_o,
  output logic                  regwren_o,
  output logic                  memren_o,
  output logic                  load_use_stall_o
);

  logic                  ex_valid_q, ex_valid_d;
  logic [AWIDTH-1:0]     pc_q, pc_d;
  logic [31:0]           insn_q, insn_d;
  logic [DWIDTH-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DWIDTH-1:0]     rs1data_q, rs1data_d, rs2data_q, rs2data_d;
  logic                  regwren_q, regwren_d, memren_q, memren_d;

  logic                  hazard, accept, hold;
  logic [REG_ADDR_W-1:0] byp1_rs, byp2_rs;
  logic [DWIDTH-1:0]     byp1_rf, byp2_rf, byp1_data, byp2_data;

  // Load in EX whose destination feeds an operand decode actually reads
  assign hazard = ex_valid_q & memren_q & (rd_q != '0) &
                  ((uses_rs1_i & (rs1_i == rd_q)) | (uses_rs2_i & (rs2_i == rd_q)));
  assign load_use_stall_o = hazard & id_valid_i;
  assign id_ready_o       = (~ex_valid_q | ex_ready_i) & ~hazard & ~flush_i;
  assign accept           = id_valid_i & id_ready_o;
  assign hold             = ex_valid_q & ~ex_ready_i;

  // The same bypass serves fresh capture (decode operands) and holding
  // (already-captured operands), so a held operand sees later writebacks.
  assign byp1_rs = accept ? rs1_i     : rs1_q;
  assign byp1_rf = accept ? rs1data_i : rs1data_q;
  assign byp2_rs = accept ? rs2_i     : rs2_q;
  assign byp2_rf = accept ? rs2data_i : rs2data_q;

  operand_bypass #(.DWIDTH(DWIDTH)) u_byp_rs1 (
    .rs_i         (byp1_rs),
    .rf_data_i    (byp1_rf),
    .wb_regwren_i (wb_regwren_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .data_o       (byp1_data)
  );

  operand_bypass #(.DWIDTH(DWIDTH)) u_byp_rs2 (
    .rs_i         (byp2_rs),
    .rf_data_i    (byp2_rf),
    .wb_regwren_i (wb_regwren_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .data_o       (byp2_data)
  );

  // Next-state: flush > accept > drain to bubble > hold with forwarding
  always_comb begin
    ex_valid_d = ex_valid_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1data_d  = rs1data_q;
    rs2data_d  = rs2data_q;
    regwren_d  = regwren_q;
    memren_d   = memren_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      regwren_d  = 1'b0;
      memren_d   = 1'b0;
      insn_d     = NOP_INSN;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      pc_d       = pc_i;
      insn_d     = insn_i;
      imm_d      = imm_i;
      rs1_d      = rs1_i;
      rs2_d      = rs2_i;
      rd_d       = rd_i;
      rs1data_d  = byp1_data;
      rs2data_d  = byp2_data;
      regwren_d  = regwren_i;
      memren_d   = memren_i;
    end else if (ex_valid_q && ex_ready_i) begin
      ex_valid_d = 1'b0;
      regwren_d  = 1'b0;
      memren_d   = 1'b0;
      insn_d     = NOP_INSN;
    end else if (hold) begin
      rs1data_d  = byp1_data;
      rs2data_d  = byp2_data;
    end
  end

  // Stage register with synchronous reset to an empty bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      insn_q     <= NOP_INSN;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1data_q  <= '0;
      rs2data_q  <= '0;
      regwren_q  <= 1'b0;
      memren_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      pc_q       <= pc_d;
      insn_q     <= insn_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1data_q  <= rs1data_d;
      rs2data_q  <= rs2data_d;
      regwren_q  <= regwren_d;
      memren_q   <= memren_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign pc_o       = pc_q;
  assign insn_o     = insn_q;
  assign imm_o      = imm_q;
  assign rs1_o      = rs1_q;
  assign rs2_o      = rs2_q;
  assign rd_o       = rd_q;
  assign rs1data_o  = rs1data_q;
  assign rs2data_o  = rs2data_q;
  assign regwren_o  = regwren_q;
  assign memren_o   = memren_q;

endmodule
